bcd_seg_mux: RTL and testbench

- Downstream display stage for the cascaded BCD counters.
- Takes NUM_DIGITS packed BCD digits (one per counter o_cnt) and time-multiplexes them onto one shared 7-segment bus with per-digit anode enables.
- Provides a refresh divider, a coherent per-scan input snapshot, leading-zero blanking, decimal points and invalid-code indication.

---
 rtl/bcd_seg_mux.sv | 140 ++++++++++++++
 tb/tb_bcd_seg_mux.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_mux.sv
// Time-multiplexed 7-segment driver for NUM_DIGITS packed BCD digits.
// Each full scan shows one coherent snapshot, with leading-zero blanking and decimal points.
module bcd_seg_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DIV_WIDTH      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [DIV_WIDTH-1:0]  DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_WIDTH-1:0]    r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snapBcd;
  logic [NUM_DIGITS-1:0]   r_snapDp;
  logic                    r_snapBlank;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                  w_divWrap;
  logic                  w_scanEnd;
  logic [NUM_DIGITS-1:0] w_blankMask;
  logic [3:0]            w_digit;
  logic                  w_digitDp;
  logic                  w_digitBlank;
  logic [6:0]            w_segRaw;
  logic [6:0]            w_segLit;
  logic [NUM_DIGITS-1:0] w_onehot;

  function automatic logic [6:0] bcdToSeg(input logic [3:0] digit);
    case (digit)
      4'd0:    bcdToSeg = 7'h3F;
      4'd1:    bcdToSeg = 7'h06;
      4'd2:    bcdToSeg = 7'h5B;
      4'd3:    bcdToSeg = 7'h4F;
      4'd4:    bcdToSeg = 7'h66;
      4'd5:    bcdToSeg = 7'h6D;
      4'd6:    bcdToSeg = 7'h7D;
      4'd7:    bcdToSeg = 7'h07;
      4'd8:    bcdToSeg = 7'h7F;
      4'd9:    bcdToSeg = 7'h6F;
      default: bcdToSeg = 7'h40;
    endcase
  endfunction

  assign w_divWrap = (r_div == DIV_LAST);
  assign w_scanEnd = i_en & w_divWrap & (r_idx == IDX_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (i_en) begin
      if (w_divWrap) begin
        r_div <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_div <= r_div + DIV_WIDTH'(1);
      end
    end
  end

  // Snapshot only at the very last cycle of a scan so every scan is coherent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snapBcd   <= '0;
      r_snapDp    <= '0;
      r_snapBlank <= 1'b0;
    end else if (w_scanEnd) begin
      r_snapBcd   <= i_bcd;
      r_snapDp    <= i_dp;
      r_snapBlank <= i_blank_lz;
    end
  end

  // Walk down from the top digit; any non-zero digit or dp stops blanking from there down.
  always_comb begin : blankLogic
    logic keep;
    keep        = 1'b0;
    w_blankMask = '0;
    for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
      keep           = keep | (r_snapBcd[4*j +: 4] != 4'h0) | r_snapDp[j];
      w_blankMask[j] = r_snapBlank & ~keep;
    end
  end

  always_comb begin
    w_digit      = 4'h0;
    w_digitDp    = 1'b0;
    w_digitBlank = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (r_idx == IDX_W'(j)) begin
        w_digit      = r_snapBcd[4*j +: 4];
        w_digitDp    = r_snapDp[j];
        w_digitBlank = w_blankMask[j];
      end
    end
  end

  assign w_segRaw = bcdToSeg(w_digit);
  assign w_segLit = w_digitBlank ? 7'h00 : w_segRaw;
  assign w_onehot = NUM_DIGITS'(1) << r_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= SEG_ACTIVE_LOW;
    end else if (i_en) begin
      r_an  <= w_onehot ^ AN_OFF;
      r_seg <= w_segLit ^ SEG_OFF;
      r_dp  <= w_digitDp ^ SEG_ACTIVE_LOW;
    end else begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= SEG_ACTIVE_LOW;
    end
  end

  assign o_an  = r_an;
  assign o_seg = r_seg;
  assign o_dp  = r_dp;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Self-checking bench for bcd_seg_mux: a 4-digit active-low instance with REFRESH_DIV=4
// checked against a scan model, plus an active-high REFRESH_DIV=1 instance.
module tb_bcd_seg_mux;

  localparam int N = 4;
  localparam int R = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst, en, blz;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;

  logic        rst2, en2, blz2;
  logic [15:0] bcd2;
  logic [3:0]  dp2;
  logic [6:0]  seg2;
  logic        dpo2;
  logic [3:0]  an2;

  int nTests = 0;
  int nFail  = 0;

  exp_t q[$];

  // Reference state: enabled-cycle count within a scan plus the snapshot.
  int          m_ec;
  logic [15:0] m_snapBcd;
  logic [3:0]  m_snapDp;
  logic        m_snapBlz;

  bcd_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(R), .DIV_WIDTH(16),
                .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bcd(bcd), .i_dp(dp),
    .i_blank_lz(blz), .o_seg(seg), .o_dp(dpo), .o_an(an));

  bcd_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(1), .DIV_WIDTH(4),
                .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_bcd(bcd2), .i_dp(dp2),
    .i_blank_lz(blz2), .o_seg(seg2), .o_dp(dpo2), .o_an(an2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d > 4'd9) ? 7'h40 : tab[d];
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    int d;
    logic blank;
    if (!en) return '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    d = (m_ec / R) % N;
    blank = 1'b0;
    if (d > 0 && m_snapBlz) begin
      blank = 1'b1;
      for (int j = d; j < N; j++)
        if (m_snapBcd[j*4 +: 4] != 4'h0 || m_snapDp[j]) blank = 1'b0;
    end
    e.an  = ~(4'b0001 << d);
    e.seg = blank ? 7'h7F : ~segOf(m_snapBcd[d*4 +: 4]);
    e.dp  = ~m_snapDp[d];
    return e;
  endfunction

  task automatic modelReset();
    m_ec      = 0;
    m_snapBcd = '0;
    m_snapDp  = '0;
    m_snapBlz = 1'b0;
  endtask

  // One clock: push the expected next output, clock, advance the model, settle.
  task automatic applyStimulus();
    q.push_back(modelOut());
    @(posedge clk);
    if (en) begin
      if (m_ec == R*N - 1) begin
        m_snapBcd = bcd;
        m_snapDp  = dp;
        m_snapBlz = blz;
      end
      m_ec = (m_ec + 1) % (R*N);
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; en = 1'b0; bcd = '0; dp = '0; blz = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; bcd2 = '0; dp2 = '0; blz2 = 1'b0;
    modelReset();
    #1;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    nTests++;
    if ({an, seg, dpo} !== e) begin
      nFail++;
      $display("[TB] FAIL reset_state got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
               an, seg, dpo, e.an, e.seg, e.dp);
    end
    nTests++;
    if ({an2, seg2, dpo2} !== 12'h000) begin
      nFail++;
      $display("[TB] FAIL reset_state2 got an=%b seg=%h dp=%b want an=0000 seg=00 dp=0",
               an2, seg2, dpo2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_scan();
    exp_t e;
    logic [6:0] want [4];
    want = '{7'h19, 7'h30, 7'h24, 7'h79};
    en = 1'b1; bcd = 16'h1234; dp = 4'b0000; blz = 1'b0;
    for (int k = 0; k < 32; k++) begin
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL first_scan k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
      nTests++;
      if (seg !== ((k < 16) ? 7'h40 : want[(k-16)/4])) begin
        nFail++;
        $display("[TB] FAIL first_scan_seg k=%0d got %h want %h", k, seg,
                 (k < 16) ? 7'h40 : want[(k-16)/4]);
      end
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    logic [6:0] wantA [4];
    logic [6:0] wantB [4];
    logic [3:0] wantDpB;
    wantA = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    wantB = '{7'h40, 7'h12, 7'h40, 7'h7F};
    wantDpB = 4'b1011;
    bcd = 16'h0050; dp = 4'b0000; blz = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 32) dp = 4'b0100;
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL blanking k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
      if (k >= 16 && k < 32) begin
        nTests++;
        if (seg !== wantA[(k-16)/4] || dpo !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL blank_lz k=%0d got seg=%h dp=%b want seg=%h dp=1",
                   k, seg, dpo, wantA[(k-16)/4]);
        end
      end
      if (k >= 48) begin
        nTests++;
        if (seg !== wantB[(k-48)/4] || dpo !== wantDpB[(k-48)/4]) begin
          nFail++;
          $display("[TB] FAIL blank_dp k=%0d got seg=%h dp=%b want seg=%h dp=%b",
                   k, seg, dpo, wantB[(k-48)/4], wantDpB[(k-48)/4]);
        end
      end
    end
  endtask

  task automatic test_invalid_midscan();
    exp_t e;
    bcd = 16'h00B0; dp = 4'b0000; blz = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (k == 20) bcd = 16'h9999;
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL invalid_midscan k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
      if (k >= 20 && k < 32) begin
        nTests++;
        if (seg !== ((k < 24) ? 7'h3F : 7'h40)) begin
          nFail++;
          $display("[TB] FAIL snapshot_hold k=%0d got %h want %h", k, seg,
                   (k < 24) ? 7'h3F : 7'h40);
        end
      end
      if (k >= 32) begin
        nTests++;
        if (seg !== 7'h10) begin
          nFail++;
          $display("[TB] FAIL snapshot_next k=%0d got %h want 10", k, seg);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    exp_t e;
    bcd = 16'h4321; dp = 4'b0000; blz = 1'b0;
    for (int k = 0; k < 42; k++) begin
      en = !(k >= 9 && k < 19);
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL enable_gap k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
      if (k >= 9 && k < 19) begin
        nTests++;
        if (an !== 4'hF || seg !== 7'h7F) begin
          nFail++;
          $display("[TB] FAIL enable_dark k=%0d got an=%b seg=%h want an=1111 seg=7f", k, an, seg);
        end
      end
      if (k >= 19 && k < 22) begin
        nTests++;
        if (an !== 4'b1011) begin
          nFail++;
          $display("[TB] FAIL enable_resume k=%0d got an=%b want 1011", k, an);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bcd = 16'h7777; dp = 4'b1111; blz = 1'b0;
    for (int k = 0; k < 13; k++) begin
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL pre_reset k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
    end
    #2 rst = 1'b1;
    #1;
    nTests++;
    if (an !== 4'hF || seg !== 7'h7F || dpo !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL async_reset got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dpo);
    end
    modelReset();
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus();
      e = q.pop_front();
      nTests++;
      if ({an, seg, dpo} !== e) begin
        nFail++;
        $display("[TB] FAIL post_reset k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, dpo, e.an, e.seg, e.dp);
      end
      nTests++;
      if (seg !== 7'h40 || an !== ~(4'b0001 << (k/4))) begin
        nFail++;
        $display("[TB] FAIL restart_zero k=%0d got an=%b seg=%h want seg=40", k, an, seg);
      end
    end
  endtask

  task automatic test_fast_active_high();
    exp_t e;
    en = 1'b0;
    rst2 = 1'b0; en2 = 1'b1; bcd2 = 16'h8888; dp2 = 4'b0000; blz2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      q.push_back('{an: 4'b0001 << (k % 4), seg: (k < 4) ? 7'h3F : 7'h7F, dp: 1'b0});
      @(posedge clk);
      #1;
      e = q.pop_front();
      nTests++;
      if ({an2, seg2, dpo2} !== e) begin
        nFail++;
        $display("[TB] FAIL fast_scan k=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an2, seg2, dpo2, e.an, e.seg, e.dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_blanking();
    test_invalid_midscan();
    test_enable_gap();
    test_reset_mid();
    test_fast_active_high();
    nTests++;
    if (q.size() != 0) begin
      nFail++;
      $display("[TB] FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
